// File: rtl/semicap_axil_pkg.sv
// Shared types and widths for the semicap AXI4-Lite register block.
// Response codes and bus widths used by the top and the register file.
package semicap_axil_pkg;

   localparam int DATA_W = 32;
   localparam int STRB_W = 4;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10
   } resp_t;

endpackage

// File: rtl/semicap_axil_regfile.sv
// Register storage with a byte-strobed write port,
// a combinational read port and a flat live view.
module semicap_axil_regfile
   import semicap_axil_pkg::*;
#(
   parameter int NUM_REGS = 4,
   parameter int IDX_W    = 3
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         we,
   input  logic [IDX_W-1:0]             waddr,
   input  logic [DATA_W-1:0]            wdata,
   input  logic [STRB_W-1:0]            wstrb,
   input  logic [IDX_W-1:0]             raddr,
   output logic [DATA_W-1:0]            rdata,
   output logic [NUM_REGS*DATA_W-1:0]   regs
);

   logic [NUM_REGS-1:0][DATA_W-1:0] mem;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem <= '0;
      end else if (we) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (waddr == IDX_W'(i)) begin
               for (int b = 0; b < STRB_W; b++) begin
                  if (wstrb[b]) mem[i][8*b +: 8] <= wdata[8*b +: 8];
               end
            end
         end
      end
   end

   always_comb begin
      rdata = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (raddr == IDX_W'(i)) rdata = mem[i];
      end
   end

   assign regs = mem;

endmodule

// File: rtl/semicap_axil_regs.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit read/write registers.
// One write and one read may be in flight at once, independently.
module semicap_axil_regs #(
   parameter int NUM_REGS = 4,
   parameter int ADDR_W   = 5
) (
   input  logic                      S_AXI_ACLK,
   input  logic                      S_AXI_ARESETN,
   input  logic [ADDR_W-1:0]         S_AXI_AWADDR,
   input  logic [2:0]                S_AXI_AWPROT,
   input  logic                      S_AXI_AWVALID,
   output logic                      S_AXI_AWREADY,
   input  logic [31:0]               S_AXI_WDATA,
   input  logic [3:0]                S_AXI_WSTRB,
   input  logic                      S_AXI_WVALID,
   output logic                      S_AXI_WREADY,
   output logic [1:0]                S_AXI_BRESP,
   output logic                      S_AXI_BVALID,
   input  logic                      S_AXI_BREADY,
   input  logic [ADDR_W-1:0]         S_AXI_ARADDR,
   input  logic [2:0]                S_AXI_ARPROT,
   input  logic                      S_AXI_ARVALID,
   output logic                      S_AXI_ARREADY,
   output logic [31:0]               S_AXI_RDATA,
   output logic [1:0]                S_AXI_RRESP,
   output logic                      S_AXI_RVALID,
   input  logic                      S_AXI_RREADY,
   output logic [NUM_REGS*32-1:0]    regs_o
);

   import semicap_axil_pkg::*;

   localparam int IDX_W = ADDR_W - 2;

   logic [1:0]        rst_sync;
   logic              rst_n;
   logic              aw_held, w_held;
   logic [IDX_W-1:0]  aw_idx;
   logic [DATA_W-1:0] w_data;
   logic [STRB_W-1:0] w_strb;
   logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic [IDX_W-1:0]  wr_idx, rd_idx;
   logic [DATA_W-1:0] wr_data, rf_rdata;
   logic [STRB_W-1:0] wr_strb;
   logic              wr_fire, wr_map, rd_map;
   resp_t             b_resp, r_resp;
   logic              unused;

   assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                     S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   // Reset asserts at once but releases two edges later.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) rst_sync <= '0;
      else                rst_sync <= {rst_sync[0], 1'b1};
   end

   assign rst_n = rst_sync[1];

   assign S_AXI_AWREADY = ~aw_held;
   assign S_AXI_WREADY  = ~w_held;
   assign S_AXI_ARREADY = ~S_AXI_RVALID;
   assign S_AXI_BRESP   = b_resp;
   assign S_AXI_RRESP   = r_resp;

   assign aw_hs = S_AXI_AWVALID & ~aw_held;
   assign w_hs  = S_AXI_WVALID & ~w_held;
   assign b_hs  = S_AXI_BVALID & S_AXI_BREADY;
   assign ar_hs = S_AXI_ARVALID & ~S_AXI_RVALID;
   assign r_hs  = S_AXI_RVALID & S_AXI_RREADY;

   // Bypass the holding registers when a half arrives this edge.
   assign wr_idx  = aw_held ? aw_idx : S_AXI_AWADDR[ADDR_W-1:2];
   assign wr_data = w_held ? w_data : S_AXI_WDATA;
   assign wr_strb = w_held ? w_strb : S_AXI_WSTRB;
   assign wr_map  = 32'(wr_idx) < 32'(NUM_REGS);
   assign wr_fire = (aw_held | aw_hs) & (w_held | w_hs) & ~S_AXI_BVALID;

   assign rd_idx = S_AXI_ARADDR[ADDR_W-1:2];
   assign rd_map = 32'(rd_idx) < 32'(NUM_REGS);

   always_ff @(posedge S_AXI_ACLK or negedge rst_n) begin
      if (!rst_n) begin
         aw_held      <= 1'b0;
         w_held       <= 1'b0;
         aw_idx       <= '0;
         w_data       <= '0;
         w_strb       <= '0;
         S_AXI_BVALID <= 1'b0;
         b_resp       <= RESP_OKAY;
      end else begin
         if (aw_hs) begin
            aw_held <= 1'b1;
            aw_idx  <= S_AXI_AWADDR[ADDR_W-1:2];
         end
         if (w_hs) begin
            w_held <= 1'b1;
            w_data <= S_AXI_WDATA;
            w_strb <= S_AXI_WSTRB;
         end
         if (wr_fire) begin
            S_AXI_BVALID <= 1'b1;
            b_resp       <= wr_map ? RESP_OKAY : RESP_SLVERR;
         end else if (b_hs) begin
            S_AXI_BVALID <= 1'b0;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
         end
      end
   end

   always_ff @(posedge S_AXI_ACLK or negedge rst_n) begin
      if (!rst_n) begin
         S_AXI_RVALID <= 1'b0;
         S_AXI_RDATA  <= '0;
         r_resp       <= RESP_OKAY;
      end else if (ar_hs) begin
         S_AXI_RVALID <= 1'b1;
         S_AXI_RDATA  <= rd_map ? rf_rdata : '0;
         r_resp       <= rd_map ? RESP_OKAY : RESP_SLVERR;
      end else if (r_hs) begin
         S_AXI_RVALID <= 1'b0;
      end
   end

   semicap_axil_regfile #(
      .NUM_REGS (NUM_REGS),
      .IDX_W    (IDX_W)
   ) u_regfile (
      .clk   (S_AXI_ACLK),
      .rst_n (rst_n),
      .we    (wr_fire & wr_map),
      .waddr (wr_idx),
      .wdata (wr_data),
      .wstrb (wr_strb),
      .raddr (rd_idx),
      .rdata (rf_rdata),
      .regs  (regs_o)
   );

endmodule

// File: tb/tb_semicap_axil_regs.sv
// Scoreboard bench for semicap_axil_regs: directed scenarios
// followed by randomized traffic against a register-array model.
module tb_semicap_axil_regs;

   localparam int NR = 4;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          arst_n;
   logic [AW-1:0] awaddr, araddr;
   logic [2:0]    awprot, arprot;
   logic          awvalid, awready, wvalid, wready;
   logic [31:0]   wdata, rdata;
   logic [3:0]    wstrb;
   logic [1:0]    bresp, rresp;
   logic          bvalid, bready, arvalid, arready;
   logic          rvalid, rready;
   logic [NR*32-1:0] regs;

   int tests = 0;
   int fails = 0;
   logic rand_rdy = 1'b0;

   logic [31:0] model [NR];
   logic [1:0]  sb_b [$];
   logic [33:0] sb_r [$];

   always #5 clk = ~clk;

   semicap_axil_regs #(.NUM_REGS(NR), .ADDR_W(AW)) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (arst_n),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWPROT  (awprot),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARPROT  (arprot),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready),
      .regs_o        (regs)
   );

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit is_mapped(input logic [AW-1:0] a);
      return (int'(a) / 4) < NR;
   endfunction

   // Scoreboard monitor: pops on each handshake, checks hold stability.
   logic       b_pend = 1'b0, r_pend = 1'b0;
   logic [1:0] b_prev;
   logic [33:0] r_prev;
   logic [1:0]  eb;
   logic [33:0] er;

   always @(negedge clk) begin
      if (!arst_n) begin
         b_pend = 1'b0;
         r_pend = 1'b0;
      end else begin
         if (b_pend) begin
            check("b_hold_valid", bvalid, 1);
            check("b_hold_resp", bresp, b_prev);
         end
         if (r_pend) begin
            check("r_hold_valid", rvalid, 1);
            check("r_hold_data", {rresp, rdata}, r_prev);
         end
         if (bvalid && bready) begin
            if (sb_b.size() == 0) check("b_unexpected", 1, 0);
            else begin
               eb = sb_b.pop_front();
               check("bresp", bresp, eb);
            end
         end
         if (rvalid && rready) begin
            if (sb_r.size() == 0) check("r_unexpected", 1, 0);
            else begin
               er = sb_r.pop_front();
               check("rdata", rdata, er[31:0]);
               check("rresp", rresp, er[33:32]);
            end
         end
         b_pend = bvalid && !bready;
         b_prev = bresp;
         r_pend = rvalid && !rready;
         r_prev = {rresp, rdata};
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_rdy) begin
            bready = ($urandom_range(0, 3) != 0);
            rready = ($urandom_range(0, 3) != 0);
         end
      end
   end

   task automatic send_aw(input logic [AW-1:0] a);
      int n = 0;
      @(posedge clk); #1;
      awaddr = a; awvalid = 1'b1;
      @(negedge clk);
      while (!awready && n < 100) begin @(negedge clk); n++; end
      check("aw_timeout", n < 100, 1);
      @(posedge clk); #1;
      awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] d, input logic [3:0] s);
      int n = 0;
      @(posedge clk); #1;
      wdata = d; wstrb = s; wvalid = 1'b1;
      @(negedge clk);
      while (!wready && n < 100) begin @(negedge clk); n++; end
      check("w_timeout", n < 100, 1);
      @(posedge clk); #1;
      wvalid = 1'b0;
   endtask

   task automatic send_ar(input logic [AW-1:0] a);
      int n = 0;
      @(posedge clk); #1;
      araddr = a; arvalid = 1'b1;
      @(negedge clk);
      while (!arready && n < 100) begin @(negedge clk); n++; end
      check("ar_timeout", n < 100, 1);
      @(posedge clk); #1;
      arvalid = 1'b0;
   endtask

   task automatic wait_b();
      int n = 0;
      while (sb_b.size() != 0 && n < 200) begin @(posedge clk); n++; end
      check("b_drain_timeout", n < 200, 1);
   endtask

   task automatic wait_r();
      int n = 0;
      while (sb_r.size() != 0 && n < 200) begin @(posedge clk); n++; end
      check("r_drain_timeout", n < 200, 1);
   endtask

   // Reference effect of a write on the model; returns expected BRESP.
   function automatic logic [1:0] model_write(input logic [AW-1:0] a,
      input logic [31:0] d, input logic [3:0] s);
      int idx = int'(a) / 4;
      if (!is_mapped(a)) return 2'b10;
      for (int b = 0; b < 4; b++)
         if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
      return 2'b00;
   endfunction

   function automatic logic [33:0] model_read(input logic [AW-1:0] a);
      if (!is_mapped(a)) return {2'b10, 32'h0};
      return {2'b00, model[int'(a) / 4]};
   endfunction

   task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d,
      input logic [3:0] s, input int da, input int dw);
      sb_b.push_back(model_write(a, d, s));
      fork
         begin repeat (da) @(posedge clk); send_aw(a); end
         begin repeat (dw) @(posedge clk); send_w(d, s); end
      join
      wait_b();
   endtask

   task automatic do_read(input logic [AW-1:0] a);
      sb_r.push_back(model_read(a));
      send_ar(a);
      wait_r();
   endtask

   task automatic check_regs(input string name);
      for (int i = 0; i < NR; i++)
         check(name, regs[32*i +: 32], model[i]);
   endtask

   initial begin
      int n;
      arst_n = 1'b0;
      awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
      awvalid = 0; wvalid = 0; arvalid = 0;
      wdata = '0; wstrb = '0; bready = 1; rready = 1;
      for (int i = 0; i < NR; i++) model[i] = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_awready", awready, 1);
      check("rst_wready", wready, 1);
      check("rst_arready", arready, 1);
      check("rst_valids", {bvalid, rvalid}, 0);
      check("rst_resp_data", {bresp, rresp, rdata}, 0);
      check_regs("rst_regs");
      @(posedge clk); #1;
      arst_n = 1'b1;
      repeat (3) @(posedge clk);

      // Basic write then readback of every register.
      for (int i = 0; i < NR; i++)
         do_write(AW'(4 * i), 32'(i + 1), 4'hF, 0, 0);
      for (int i = 0; i < NR; i++) do_read(AW'(4 * i));
      check("regs_basic", regs, 128'h00000004_00000003_00000002_00000001);

      // W leads AW by three edges with a partial strobe.
      sb_b.push_back(model_write(5'h08, 32'hDEADBEEF, 4'b0101));
      send_w(32'hDEADBEEF, 4'b0101);
      check("w_first_wready", wready, 0);
      check("w_first_bvalid", bvalid, 0);
      @(posedge clk); #1;
      check("w_wait_bvalid", bvalid, 0);
      check("w_wait_wready", wready, 0);
      send_aw(5'h08);
      check("aw_edge_bvalid", bvalid, 1);
      wait_b();
      check("strobe_merge", regs[95:64], 32'h00AD00EF);

      // Unmapped accesses.
      do_write(5'h10, 32'hFFFFFFFF, 4'hF, 0, 0);
      do_read(5'h14);
      check_regs("unmapped_regs");

      // B backpressure, second write held off until B handshake.
      bready = 1'b0;
      sb_b.push_back(model_write(5'h0C, 32'hA5A50001, 4'hF));
      fork
         send_aw(5'h0C);
         send_w(32'hA5A50001, 4'hF);
      join
      awaddr = 5'h0C; awvalid = 1'b1;
      wdata = 32'h5A5A0002; wstrb = 4'hF; wvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("bp_bvalid", bvalid, 1);
         check("bp_bresp", bresp, 0);
         check("bp_awready", awready, 0);
         check("bp_wready", wready, 0);
         @(posedge clk); #1;
      end
      sb_b.push_back(model_write(5'h0C, 32'h5A5A0002, 4'hF));
      bready = 1'b1;
      n = 0;
      @(negedge clk);
      while (!awready && n < 50) begin @(negedge clk); n++; end
      check("bp_aw_after_b", sb_b.size(), 1);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      wait_b();
      check("bp_reg3", regs[127:96], 32'h5A5A0002);

      // Read and write to the same register on one edge.
      sb_r.push_back(model_read(5'h04));
      sb_b.push_back(model_write(5'h04, 32'h55, 4'hF));
      fork
         send_aw(5'h04);
         send_w(32'h55, 4'hF);
         send_ar(5'h04);
      join
      wait_b();
      wait_r();
      do_read(5'h04);

      // Reset between AW and W abandons the write.
      send_aw(5'h00);
      arst_n = 1'b0;
      #1;
      check("rst_mid_bvalid", bvalid, 0);
      check("rst_mid_ready", {awready, wready}, 2'b11);
      for (int i = 0; i < NR; i++) model[i] = '0;
      check_regs("rst_mid_regs");
      repeat (3) @(posedge clk);
      #1;
      arst_n = 1'b1;
      awaddr = 5'h00; awvalid = 1'b1;
      wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
      sb_b.push_back(model_write(5'h00, 32'h77, 4'hF));
      n = 0;
      do begin
         @(posedge clk); n++; #1;
      end while (!bvalid && n < 20);
      check("release_latency_ok", n >= 2 && n < 20, 1);
      awvalid = 1'b0; wvalid = 1'b0;
      wait_b();
      check_regs("post_release_regs");

      // Randomized serial traffic with random backpressure.
      rand_rdy = 1'b1;
      for (int k = 0; k < 60; k++) begin
         logic [AW-1:0] a;
         a = ($urandom_range(0, 9) < 8) ? AW'($urandom_range(0, 15))
                                        : AW'($urandom_range(16, 31));
         if ($urandom_range(0, 1) == 1)
            do_write(a, $urandom, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 3), $urandom_range(0, 3));
         else
            do_read(a);
      end
      rand_rdy = 1'b0;
      @(posedge clk); #1;
      bready = 1'b1; rready = 1'b1;
      repeat (2) @(posedge clk);
      check_regs("final_regs");
      check("sb_b_empty", sb_b.size(), 0);
      check("sb_r_empty", sb_r.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/semicap_axil_regs.md
SEMICAP_AXIL_REGS -- requirements
Module: semicap_axil_regs

Interface
REQ-001 Parameter NUM_REGS, default 4: number of 32-bit read/write registers.
REQ-002 Parameter ADDR_W, default 5: byte-address width; addresses at or above NUM_REGS*4 are unmapped.
REQ-003 Port S_AXI_ACLK  input  1: single clock; all logic is rising-edge.
REQ-004 Port S_AXI_ARESETN  input  1: asynchronous, active-low reset.
REQ-005 Write-address ports: S_AXI_AWADDR input ADDR_W; S_AXI_AWPROT input 3, ignored; S_AXI_AWVALID input 1; S_AXI_AWREADY output 1.
REQ-006 Write-data ports: S_AXI_WDATA input 32; S_AXI_WSTRB input 4; S_AXI_WVALID input 1; S_AXI_WREADY output 1.
REQ-007 Write-response ports: S_AXI_BRESP output 2; S_AXI_BVALID output 1; S_AXI_BREADY input 1.
REQ-008 Read-address ports: S_AXI_ARADDR input ADDR_W; S_AXI_ARPROT input 3, ignored; S_AXI_ARVALID input 1; S_AXI_ARREADY output 1.
REQ-009 Read-data ports: S_AXI_RDATA output 32; S_AXI_RRESP output 2; S_AXI_RVALID output 1; S_AXI_RREADY input 1.
REQ-010 Port regs_o  output  NUM_REGS*32: live register contents; register n occupies bits [32n+31:32n].

Function
REQ-011 Each channel handshake SHALL complete on a rising edge where VALID and READY are both high; VALID SHALL never depend combinationally on READY.
REQ-012 Write path SHALL hold two flags, aw_held and w_held, each set by its own handshake; AWREADY = !aw_held and WREADY = !w_held.
REQ-013 AW and W SHALL be accepted in either order or in the same cycle; the address and data/strobe SHALL be latched at their respective handshakes.
REQ-014 On the edge where both flags become true (or are already true), the register write SHALL take effect and BVALID SHALL rise on that same edge.
REQ-015 Write SHALL update only the bytes whose WSTRB bit is 1; WSTRB=0 SHALL leave the register unchanged and still return OKAY.
REQ-016 Both flags SHALL clear on the B handshake; neither AWREADY nor WREADY SHALL reassert before then, so at most one write is outstanding.
REQ-017 Address decode SHALL use ADDR[ADDR_W-1:2]; ADDR[1:0] SHALL be ignored.
REQ-018 Mapped write: BRESP=2'b00 (OKAY); unmapped write: BRESP=2'b10 (SLVERR) with no register change.
REQ-019 BVALID and BRESP SHALL hold stable until BREADY is sampled high.
REQ-020 Read path: ARREADY = !RVALID; on the AR handshake RDATA/RRESP SHALL be loaded and RVALID SHALL rise on that same edge.
REQ-021 Mapped read: RDATA = register value, RRESP=OKAY; unmapped read: RDATA=0, RRESP=SLVERR.
REQ-022 RVALID, RDATA and RRESP SHALL hold stable until RREADY is sampled high; RVALID SHALL clear on the R handshake.
REQ-023 When a read and a write to the same register complete on the same edge, the read SHALL return the pre-write value.
REQ-024 Read and write paths SHALL operate independently and concurrently.
REQ-025 With BREADY/RREADY tied high, sustained throughput SHALL be one write per 2 cycles and one read per 2 cycles.

Reset
REQ-026 While S_AXI_ARESETN is low, all registers, aw_held, w_held, BVALID, RVALID, BRESP, RRESP and RDATA SHALL be 0, and AWREADY, WREADY and ARREADY SHALL be 1 (computed from cleared flags).
REQ-027 Assertion of reset mid-transaction SHALL abandon any pending write without updating registers and drop any pending response immediately.
REQ-028 Release SHALL be synchronised inside the block, so that the first handshake is accepted no earlier than the second rising edge after deassertion.

Structure
REQ-029 Package semicap_axil_pkg SHALL hold the resp_t typedef with OKAY=2'b00 and SLVERR=2'b10, plus the 32-bit data width and 4-bit strobe width constants.
REQ-030 Register storage and byte-strobe merge SHALL be one sub-module, semicap_axil_regfile, which provides one write port, one combinational read port and the regs_o output.

Verification
REQ-031 Write 0x1, 0x2, 0x3, 0x4 to 0x0/0x4/0x8/0xC, then read each back -> RDATA 0x1..0x4, all responses OKAY, regs_o = 0x00000004_00000003_00000002_00000001.
REQ-032 Drive W (0xDEADBEEF, WSTRB=4'b0101) 3 cycles before AW to 0x8, with register 2 previously 0x00000003 -> WREADY drops after W, BVALID rises on the AW edge, register 2 = 0x00AD00EF.
REQ-033 Write to 0x10 and read from 0x14 -> BRESP=SLVERR and RRESP=SLVERR with RDATA=0; all registers unchanged.
REQ-034 Hold BREADY low 5 cycles after a write -> BVALID and BRESP stable, AWREADY/WREADY low throughout; a second AW is accepted only after the B handshake.
REQ-035 Issue AR and AW+W to 0x4 on the same edge with old value 0x2 and new value 0x55 -> RDATA=0x2, then a subsequent read returns 0x55.
REQ-036 Assert reset after AW is accepted but before W -> BVALID stays 0, the register is unchanged, and AWREADY=WREADY=1 after release.
